// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot host: FSM state encoding,
// default sync bytes and a little-endian byte-select helper.
package uart_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SYNC_PROG,
      ST_SEND_SIZE,
      ST_SEND_PROG,
      ST_WAIT_SYNC_STDIN,
      ST_SEND_STDIN,
      ST_CAPTURE
   } boot_state_t;

   localparam logic [7:0] SYNC_PROG_DEF  = 8'h99;
   localparam logic [7:0] SYNC_STDIN_DEF = 8'hAA;

   // Byte idx of a 32-bit word, byte 0 = bits 7:0.
   function automatic logic [7:0] le_byte(
      input logic [31:0] w,
      input logic [1:0]  idx
   );
      logic [7:0] b;
      b = w[7:0];
      unique case (idx)
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         2'd3: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Paces byte hand-off to a UART transmitter.
// Ports: i_req/i_data = byte offered by the host, o_accept = byte taken
// this cycle; o_tx_start/o_tx_data = registered strobe and data to the
// transmitter; i_tx_busy = transmitter busy.
module uart_tx_pacer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_req,
   input  logic [7:0] i_data,
   input  logic       i_tx_busy,
   output logic       o_accept,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data
);

   logic       r_tx_start;
   logic [7:0] r_tx_data;

   // Blocking on our own previous strobe leaves the transmitter one
   // cycle to raise busy before the next byte can be issued.
   assign o_accept = i_req & ~i_tx_busy & ~r_tx_start;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
      end else begin
         r_tx_start <= o_accept;
         if (o_accept) r_tx_data <= i_data;
      end
   end

   assign o_tx_start = r_tx_start;
   assign o_tx_data  = r_tx_data;

endmodule

// File: rtl/uart_boot_host.sv
// Boot host: waits for the target's sync bytes, sends program size, program
// words and stdin over UART, then captures the target's output bytes.
// Ports: i_start/i_prog_len_words start a run; o_prog_addr/i_prog_rdata and
// o_stdin_addr/i_stdin_rdata read sources (1-cycle latency); o_tx_* and
// i_tx_busy drive the transmitter; i_rx_* come from the receiver;
// o_res_* write the result buffer; o_busy/o_done/o_err_* report status.
module uart_boot_host
   import uart_boot_pkg::*;
#(
   parameter int         PROG_WORDS_MAX = 1024,
   parameter int         STDIN_BYTES    = 32,
   parameter int         RESULT_DEPTH   = 4096,
   parameter logic [7:0] SYNC_PROG      = SYNC_PROG_DEF,
   parameter logic [7:0] SYNC_STDIN     = SYNC_STDIN_DEF,
   parameter int         IDLE_TIMEOUT   = 100000,
   localparam int LW  = $clog2(PROG_WORDS_MAX + 1),
   localparam int PAW = (PROG_WORDS_MAX > 1) ? $clog2(PROG_WORDS_MAX) : 1,
   localparam int SAW = (STDIN_BYTES > 1) ? $clog2(STDIN_BYTES) : 1,
   localparam int RAW = $clog2(RESULT_DEPTH),
   localparam int CW  = RAW + 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           i_start,
   input  logic [LW-1:0]  i_prog_len_words,
   output logic [PAW-1:0] o_prog_addr,
   input  logic [31:0]    i_prog_rdata,
   output logic [SAW-1:0] o_stdin_addr,
   input  logic [7:0]     i_stdin_rdata,
   output logic [7:0]     o_tx_data,
   output logic           o_tx_start,
   input  logic           i_tx_busy,
   input  logic [7:0]     i_rx_data,
   input  logic           i_rx_valid,
   input  logic           i_rx_ferr,
   output logic           o_res_we,
   output logic [RAW-1:0] o_res_waddr,
   output logic [7:0]     o_res_wdata,
   output logic [CW-1:0]  o_res_count,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_err_ferr,
   output logic           o_err_overflow
);

   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   boot_state_t    r_state;
   logic [LW-1:0]  r_len;
   logic [1:0]     r_bidx;
   logic [PAW-1:0] r_prog_addr;
   logic [SAW-1:0] r_stdin_addr;
   logic           r_fetch;
   logic [CW-1:0]  r_res_count;
   logic [TW-1:0]  r_idle;
   logic           r_busy;
   logic           r_done;
   logic           r_err_ferr;
   logic           r_err_ovf;

   logic [LW-1:0]  w_len_clamped;
   logic [31:0]    w_size;
   logic           w_req;
   logic [7:0]     w_byte;
   logic           w_accept;
   logic           w_rx_ok;
   logic           w_cap;
   logic           w_full;
   logic           w_last_word;
   logic           w_last_stdin;

   assign w_len_clamped = (i_prog_len_words > LW'(PROG_WORDS_MAX))
                        ? LW'(PROG_WORDS_MAX) : i_prog_len_words;
   assign w_size = {{(30 - LW){1'b0}}, r_len, 2'b00};

   assign w_rx_ok = i_rx_valid & ~i_rx_ferr;
   assign w_cap   = (r_state == ST_SEND_STDIN) | (r_state == ST_CAPTURE);
   assign w_full  = (r_res_count == CW'(RESULT_DEPTH));

   assign w_last_word  = (LW'(r_prog_addr) + LW'(1)) == r_len;
   assign w_last_stdin = (r_stdin_addr == SAW'(STDIN_BYTES - 1));

   // r_fetch masks the cycle after a read-address step, so source data
   // is only consumed once its one-cycle read latency has elapsed.
   always_comb begin
      w_req  = 1'b0;
      w_byte = 8'h00;
      unique case (r_state)
         ST_SEND_SIZE: begin
            w_req  = 1'b1;
            w_byte = le_byte(w_size, r_bidx);
         end
         ST_SEND_PROG: begin
            w_req  = ~r_fetch;
            w_byte = le_byte(i_prog_rdata, r_bidx);
         end
         ST_SEND_STDIN: begin
            w_req  = ~r_fetch;
            w_byte = i_stdin_rdata;
         end
         default: ;
      endcase
   end

   uart_tx_pacer u_pacer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_req      (w_req),
      .i_data     (w_byte),
      .i_tx_busy  (i_tx_busy),
      .o_accept   (w_accept),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_bidx       <= 2'd0;
         r_prog_addr  <= '0;
         r_stdin_addr <= '0;
         r_fetch      <= 1'b0;
         r_res_count  <= '0;
         r_idle       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err_ferr   <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         r_fetch <= 1'b0;
         if (o_res_we) r_res_count <= r_res_count + 1'b1;
         if (w_cap & w_rx_ok & w_full) r_err_ovf <= 1'b1;
         if ((r_state != ST_IDLE) & i_rx_valid & i_rx_ferr)
            r_err_ferr <= 1'b1;

         unique case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state      <= ST_WAIT_SYNC_PROG;
                  r_len        <= w_len_clamped;
                  r_bidx       <= 2'd0;
                  r_prog_addr  <= '0;
                  r_stdin_addr <= '0;
                  r_res_count  <= '0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_err_ferr   <= 1'b0;
                  r_err_ovf    <= 1'b0;
               end
            end
            ST_WAIT_SYNC_PROG: begin
               if (w_rx_ok && i_rx_data == SYNC_PROG) begin
                  r_state <= ST_SEND_SIZE;
                  r_bidx  <= 2'd0;
               end
            end
            ST_SEND_SIZE: begin
               if (w_accept) begin
                  r_bidx <= r_bidx + 2'd1;
                  if (r_bidx == 2'd3)
                     r_state <= (r_len == '0) ? ST_WAIT_SYNC_STDIN
                                              : ST_SEND_PROG;
               end
            end
            ST_SEND_PROG: begin
               if (w_accept) begin
                  r_bidx <= r_bidx + 2'd1;
                  if (r_bidx == 2'd3) begin
                     if (w_last_word) begin
                        r_state <= ST_WAIT_SYNC_STDIN;
                     end else begin
                        r_prog_addr <= r_prog_addr + 1'b1;
                        r_fetch     <= 1'b1;
                     end
                  end
               end
            end
            ST_WAIT_SYNC_STDIN: begin
               if (w_rx_ok && i_rx_data == SYNC_STDIN)
                  r_state <= ST_SEND_STDIN;
            end
            ST_SEND_STDIN: begin
               if (w_accept) begin
                  if (w_last_stdin) begin
                     r_state <= ST_CAPTURE;
                     r_idle  <= '0;
                  end else begin
                     r_stdin_addr <= r_stdin_addr + 1'b1;
                     r_fetch      <= 1'b1;
                  end
               end
            end
            ST_CAPTURE: begin
               if (i_rx_valid) begin
                  r_idle <= '0;
               end else if (r_idle == TW'(IDLE_TIMEOUT - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idle <= r_idle + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Write strobe is combinational so data lands in the rx_valid cycle.
   assign o_res_we       = reset_n & w_cap & w_rx_ok & ~w_full;
   assign o_res_waddr    = r_res_count[RAW-1:0];
   assign o_res_wdata    = i_rx_data;
   assign o_res_count    = r_res_count;
   assign o_prog_addr    = r_prog_addr;
   assign o_stdin_addr   = r_stdin_addr;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err_ferr     = r_err_ferr;
   assign o_err_overflow = r_err_ovf;

endmodule

// File: tb/tb_uart_boot_host.sv
// Scoreboard bench for uart_boot_host: expected tx bytes and result writes
// are queued by the stimulus and popped by a negedge monitor.
module tb_uart_boot_host;

   localparam int PW = 8;
   localparam int SB = 4;
   localparam int RD = 16;
   localparam int IT = 64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  len = 4'd0;
   logic [2:0]  prog_addr;
   logic [31:0] prog_rdata = 32'h0;
   logic [1:0]  stdin_addr;
   logic [7:0]  stdin_rdata = 8'h0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [7:0]  rx_data = 8'h0;
   logic        rx_valid = 1'b0;
   logic        rx_ferr = 1'b0;
   logic        res_we;
   logic [3:0]  res_waddr;
   logic [7:0]  res_wdata;
   logic [4:0]  res_count;
   logic        busy, done, err_ferr, err_ovf;

   logic [31:0] prog_mem [PW];
   logic [7:0]  stdin_mem [SB];
   logic [7:0]  exp_tx [$];
   logic [11:0] exp_wr [$];
   logic [7:0]  e_tx;
   logic [11:0] e_wr;
   logic        prev_start = 1'b0;
   int          bcnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   uart_boot_host #(
      .PROG_WORDS_MAX (PW),
      .STDIN_BYTES    (SB),
      .RESULT_DEPTH   (RD),
      .IDLE_TIMEOUT   (IT)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_start          (start),
      .i_prog_len_words (len),
      .o_prog_addr      (prog_addr),
      .i_prog_rdata     (prog_rdata),
      .o_stdin_addr     (stdin_addr),
      .i_stdin_rdata    (stdin_rdata),
      .o_tx_data        (tx_data),
      .o_tx_start       (tx_start),
      .i_tx_busy        (tx_busy),
      .i_rx_data        (rx_data),
      .i_rx_valid       (rx_valid),
      .i_rx_ferr        (rx_ferr),
      .o_res_we         (res_we),
      .o_res_waddr      (res_waddr),
      .o_res_wdata      (res_wdata),
      .o_res_count      (res_count),
      .o_busy           (busy),
      .o_done           (done),
      .o_err_ferr       (err_ferr),
      .o_err_overflow   (err_ovf)
   );

   always @(posedge clk) begin
      prog_rdata  <= prog_mem[prog_addr];
      stdin_rdata <= stdin_mem[stdin_addr];
   end

   // Transmitter model: busy for 3 cycles after each strobe.
   always @(posedge clk) begin
      if (!reset_n) bcnt <= 0;
      else if (tx_start) bcnt <= 3;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign tx_busy = (bcnt != 0);

   always @(negedge clk) begin
      if (reset_n && tx_start) begin
         checks++;
         if (tx_busy || prev_start) begin
            errors++;
            $display("FAIL tx_pace: busy=%0b prev_start=%0b required 0 0",
                     tx_busy, prev_start);
         end
         checks++;
         if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_byte: got %02h, required no byte", tx_data);
         end else begin
            e_tx = exp_tx.pop_front();
            if (tx_data !== e_tx) begin
               errors++;
               $display("FAIL tx_byte: got %02h required %02h", tx_data, e_tx);
            end
         end
      end
      prev_start = tx_start;
      if (res_we) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL res_write: got a%0d=%02h, required no write",
                     res_waddr, res_wdata);
         end else begin
            e_wr = exp_wr.pop_front();
            if ({res_waddr, res_wdata} !== e_wr) begin
               errors++;
               $display("FAIL res_write: got a%0d=%02h required a%0d=%02h",
                        res_waddr, res_wdata, e_wr[11:8], e_wr[7:0]);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic rx(input logic [7:0] b, input logic f);
      rx_data  = b;
      rx_ferr  = f;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      tick();
   endtask

   task automatic do_start(input logic [3:0] l);
      len   = l;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic drain(input string nm, input int lim);
      int n = 0;
      while (exp_tx.size() != 0 && n < lim) begin
         tick();
         n++;
      end
      chk(nm, exp_tx.size(), 0);
      exp_tx.delete();
   endtask

   task automatic wait_done(input string nm, input int lim);
      int n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
      chk(nm, done, 1);
   endtask

   task automatic push_stdin();
      for (int i = 0; i < SB; i++) exp_tx.push_back(stdin_mem[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      prog_mem[0] = 32'h11223344;
      prog_mem[1] = 32'hAABBCCDD;
      for (int i = 2; i < PW; i++) prog_mem[i] = 32'h5060_7000 + i;
      for (int i = 0; i < SB; i++) stdin_mem[i] = 8'hA0 + 8'(i);

      tick(3);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_res_we", res_we, 0);
      reset_n = 1'b1;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_errs", {err_ferr, err_ovf}, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_addrs", {prog_addr, stdin_addr}, 0);

      // Run 1: two words, ignored byte, stdin with capture, ferr, timeout.
      do_start(4'd2);
      chk("run1_busy", busy, 1);
      rx(8'h42, 1'b0);
      tick(20);
      chk("run1_ignored_count", res_count, 0);
      chk("run1_ignored_no_tx", tx_start, 0);
      exp_tx = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      rx(8'h99, 1'b0);
      drain("run1_prog_drain", 400);
      push_stdin();
      exp_wr = '{{4'd0, 8'h51}, {4'd1, 8'h52}, {4'd2, 8'h53}};
      rx(8'hAA, 1'b0);
      rx(8'h51, 1'b0);
      rx(8'h52, 1'b0);
      rx(8'h53, 1'b0);
      drain("run1_stdin_drain", 400);
      tick(4);
      rx(8'h77, 1'b1);
      chk("run1_err_ferr", err_ferr, 1);
      chk("run1_count", res_count, 3);
      tick(50);
      chk("run1_done_early", done, 0);
      wait_done("run1_done", 100);
      chk("run1_busy_end", busy, 0);
      chk("run1_ovf", err_ovf, 0);
      chk("run1_wr_left", exp_wr.size(), 0);

      // Run 2: zero-length program, buffer overflow.
      do_start(4'd0);
      chk("run2_cleared", {done, err_ferr, err_ovf}, 0);
      chk("run2_count0", res_count, 0);
      exp_tx = '{8'h00, 8'h00, 8'h00, 8'h00};
      rx(8'h99, 1'b0);
      drain("run2_size_drain", 400);
      push_stdin();
      rx(8'hAA, 1'b0);
      drain("run2_stdin_drain", 400);
      tick(2);
      for (int i = 0; i < RD; i++)
         exp_wr.push_back({4'(i), 8'h80 + 8'(i)});
      for (int i = 0; i < 20; i++) rx(8'h80 + 8'(i), 1'b0);
      chk("run2_count16", res_count, 16);
      chk("run2_ovf", err_ovf, 1);
      chk("run2_ferr", err_ferr, 0);
      wait_done("run2_done", 200);
      chk("run2_wr_left", exp_wr.size(), 0);

      // Run 3: reset in the middle of the program send.
      do_start(4'd2);
      exp_tx = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      rx(8'h99, 1'b0);
      begin
         int n = 0;
         while (exp_tx.size() > 5 && n < 400) begin
            tick();
            n++;
         end
      end
      chk("run3_reached_prog", exp_tx.size(), 5);
      reset_n = 1'b0;
      tick();
      chk("run3_rst_tx_start", tx_start, 0);
      chk("run3_rst_tx_data", tx_data, 0);
      chk("run3_rst_busy", busy, 0);
      chk("run3_rst_addr", prog_addr, 0);
      reset_n = 1'b1;
      exp_tx.delete();
      tick(2);

      // Run 4: length 9 clamps to 8 words.
      do_start(4'd9);
      exp_tx = '{8'h20, 8'h00, 8'h00, 8'h00};
      for (int w = 0; w < PW; w++)
         for (int b = 0; b < 4; b++)
            exp_tx.push_back(prog_mem[w][8*b +: 8]);
      rx(8'h99, 1'b0);
      drain("run4_prog_drain", 2000);
      chk("run4_last_addr", prog_addr, 7);
      push_stdin();
      rx(8'hAA, 1'b0);
      drain("run4_stdin_drain", 400);
      wait_done("run4_done", 200);
      chk("run4_count", res_count, 0);
      chk("run4_stdin_addr", stdin_addr, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_boot_host.md
UART_BOOT_HOST -- requirements
Module: uart_boot_host

Interface
REQ-001 Parameter PROG_WORDS_MAX, default 1024; max program words sendable.
REQ-002 Parameter STDIN_BYTES, default 32; stdin bytes sent per run, legal range >=1.
REQ-003 Parameter RESULT_DEPTH, default 4096; result buffer entries, power of two.
REQ-004 Parameter SYNC_PROG, default 8'h99; target request-for-program byte.
REQ-005 Parameter SYNC_STDIN, default 8'hAA; target request-for-stdin byte.
REQ-006 Parameter IDLE_TIMEOUT, default 100000; clk cycles of rx silence that end capture.
REQ-007 clk  in  1  clock; reset reset_n, synchronous, active-low.
REQ-008 reset_n  in  1  synchronous active-low reset.
REQ-009 start  in  1  single-cycle pulse; begins a run when in IDLE, ignored otherwise.
REQ-010 prog_len_words  in  $clog2(PROG_WORDS_MAX+1)  words to send; sampled on start.
REQ-011 prog_addr  out  $clog2(PROG_WORDS_MAX)  program word read address.
REQ-012 prog_rdata  in  32  program word; valid one cycle after prog_addr changes.
REQ-013 stdin_addr  out  $clog2(STDIN_BYTES)  stdin byte read address.
REQ-014 stdin_rdata  in  8  stdin byte; valid one cycle after stdin_addr changes.
REQ-015 tx_data  out  8  byte to UART transmitter.
REQ-016 tx_start  out  1  one-cycle transmit strobe.
REQ-017 tx_busy  in  1  transmitter busy.
REQ-018 rx_data  in  8  received byte.
REQ-019 rx_valid  in  1  one-cycle received-byte strobe.
REQ-020 rx_ferr  in  1  framing error qualifying rx_valid.
REQ-021 res_we, res_waddr, res_wdata  out  1/$clog2(RESULT_DEPTH)/8  result buffer write port.
REQ-022 res_count  out  $clog2(RESULT_DEPTH)+1  bytes captured this run.
REQ-023 busy, done, err_ferr, err_overflow  out  1 each  status; done/err_* sticky until next start.

Function
REQ-024 FSM states: IDLE, WAIT_SYNC_PROG, SEND_SIZE, SEND_PROG, WAIT_SYNC_STDIN, SEND_STDIN, CAPTURE.
REQ-025 IDLE->WAIT_SYNC_PROG on start; clears done, err_*, res_count; busy=1 outside IDLE.
REQ-026 WAIT_SYNC_*: advance only on rx_valid & ~rx_ferr & rx_data==sync byte; other bytes discarded, not captured.
REQ-027 TX rule: tx_start pulses one cycle only when ~tx_busy and no pulse in previous cycle (one-cycle gap for tx_busy rise); tx_data held stable from pulse until next pulse.
REQ-028 SEND_SIZE: 4 bytes of prog_len_words*4, little-endian (byte 0 = bits 7:0); then SEND_PROG, or WAIT_SYNC_STDIN if prog_len_words==0.
REQ-029 SEND_PROG: words 0..prog_len_words-1, each little-endian, 4*prog_len_words bytes total; prog_rdata never used before one cycle after prog_addr update.
REQ-030 SEND_STDIN: stdin bytes 0..STDIN_BYTES-1 in order, then CAPTURE.
REQ-031 Capture active in SEND_STDIN and CAPTURE: each rx_valid & ~rx_ferr writes rx_data at res_waddr=res_count, same cycle as res_we; res_count+1 next cycle.
REQ-032 rx_valid with rx_ferr in any non-IDLE state: byte dropped, err_ferr set.
REQ-033 Buffer full (res_count==RESULT_DEPTH): further bytes dropped, no res_we, err_overflow set, res_count saturates.
REQ-034 CAPTURE: silence counter reset on every rx_valid; reaching IDLE_TIMEOUT -> done=1 for the run, state IDLE.
REQ-035 prog_len_words > PROG_WORDS_MAX clamps to PROG_WORDS_MAX.
REQ-036 rx_valid coinciding with tx_start: both processed, neither lost.

Reset
REQ-037 reset_n low (any state, including mid-byte): state IDLE, tx_start=0, tx_data=0, res_we=0, addresses 0, res_count 0, busy/done/err_* 0.

Structure
REQ-038 State enum and default SYNC_PROG/SYNC_STDIN constants live in shared package uart_boot_pkg.
REQ-039 Single sub-module uart_tx_pacer implements REQ-027 handshake; all else in the top.

Verification
REQ-040 prog_len_words=2, words 32'h11223344, 32'hAABBCCDD, rx 8'h99 -> tx 08 00 00 00 44 33 22 11 DD CC BB AA.
REQ-041 rx 8'h42 then 8'h99 -> 8'h42 ignored, size sent after 8'h99 only, res_count stays 0.
REQ-042 rx 8'hAA, STDIN_BYTES=4 -> 4 stdin bytes sent; 3 rx bytes during stdin send captured at addresses 0..2.
REQ-043 RESULT_DEPTH=16, 20 rx bytes -> 16 writes, res_count=16, err_overflow=1.
REQ-044 rx byte with rx_ferr=1 in CAPTURE -> no write, err_ferr=1; then IDLE_TIMEOUT silence -> done=1, busy=0.
REQ-045 reset_n low during SEND_PROG -> next cycle state IDLE, tx_start=0; new start reruns full sequence.
